// File: rtl/lcd_line_sched_pkg.sv
//------------------------------------------------------------------------------
// Module   : lcd_pkg
// Brief    : Shared types and constants for the LCD line-update scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcd_pkg;

  localparam int          LINE_LEN_DEF      = 16;
  localparam logic [7:0]  LINE0_ADDR_DEF    = 8'h00;
  localparam logic [7:0]  LINE1_ADDR_DEF    = 8'h40;
  localparam logic [7:0]  LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0]  LCD_CHAR_SPACE    = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ACK   = 3'd2,
    ST_BUSYW = 3'd3,
    ST_FETCH = 3'd4,
    ST_DATA  = 3'd5,
    ST_DONE  = 3'd6
  } lcd_state_e;

  // Unwritten text RAM reads as 0; show it as a blank cell.
  function automatic logic [7:0] lcd_pad_char(input logic [7:0] c);
    return (c == 8'h00) ? LCD_CHAR_SPACE : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_line_sched_rr_arb2.sv
//------------------------------------------------------------------------------
// Module   : lcd_rr_arb2
// Brief    : Two-way round-robin arbiter holding per-line pending redraws.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_start,
  input  logic       i_grant_take,
  input  logic [1:0] i_done,
  output logic       o_grant_valid,
  output logic       o_grant
);

  logic [1:0] r_pending;
  logic       r_last_grant;
  logic [1:0] w_clr;

  assign o_grant_valid = |r_pending;
  // On a tie the line that was not served last wins.
  assign o_grant       = (r_pending == 2'b11) ? ~r_last_grant : r_pending[1];
  assign w_clr         = i_grant_take ? (o_grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending    <= 2'b00;
      r_last_grant <= 1'b1;
    end else begin
      r_pending <= (r_pending & ~w_clr) | i_start;
      if (i_done[0])
        r_last_grant <= 1'b0;
      else if (i_done[1])
        r_last_grant <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_line_sched.sv
//------------------------------------------------------------------------------
// Module   : lcd_line_sched
// Brief    : Round-robin 16x2 LCD line redraw sequencer (set-address + chars).
//            Optional macro LCD_BLANK_PAD_EN writes 8'h00 characters as spaces.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_line_sched
  import lcd_pkg::*;
#(
  parameter int         LINE_LEN   = LINE_LEN_DEF,
  parameter logic [7:0] LINE0_ADDR = LINE0_ADDR_DEF,
  parameter logic [7:0] LINE1_ADDR = LINE1_ADDR_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [1:0]                 start,
  output logic [1:0]                 done,
  output logic [$clog2(LINE_LEN):0]  char_addr,
  input  logic [7:0]                 char_data,
  output logic                       lcd_we,
  output logic                       lcd_rs,
  output logic [7:0]                 lcd_data,
  input  logic                       lcd_busy,
  output logic                       active
);

  localparam int                 c_IDX_W    = $clog2(LINE_LEN) + 1;
  localparam logic [c_IDX_W-1:0] c_LINE_END = c_IDX_W'(LINE_LEN);

  lcd_state_e         r_state, w_next;
  logic               r_grant;
  logic [c_IDX_W-1:0] r_idx;
  logic [1:0]         r_done;

  logic       w_grant_valid, w_arb_grant, w_take, w_idx_inc;
  logic [1:0] w_done_now;
  logic [7:0] w_base, w_char;

  lcd_rr_arb2 u_arb (
    .clk           (CLK),
    .rst_n         (RST),
    .i_start       (start),
    .i_grant_take  (w_take),
    .i_done        (w_done_now),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_arb_grant)
  );

  assign w_base = r_grant ? LINE1_ADDR : LINE0_ADDR;

`ifdef LCD_BLANK_PAD_EN
  assign w_char = lcd_pad_char(char_data);
`else
  assign w_char = char_data;
`endif

  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    w_idx_inc  = 1'b0;
    w_done_now = 2'b00;
    lcd_we     = 1'b0;
    lcd_rs     = 1'b0;
    lcd_data   = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_take = 1'b1;
          w_next = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!lcd_busy) begin
          lcd_we   = 1'b1;
          lcd_data = LCD_CMD_SET_DDRAM | w_base;
          w_next   = ST_ACK;
        end
      end
      // Driver raises busy one cycle after the strobe, so skip that cycle.
      ST_ACK:   w_next = ST_BUSYW;
      ST_BUSYW: begin
        if (!lcd_busy)
          w_next = (r_idx == c_LINE_END) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: w_next = ST_DATA;
      ST_DATA: begin
        lcd_we    = 1'b1;
        lcd_rs    = 1'b1;
        lcd_data  = w_char;
        w_idx_inc = 1'b1;
        w_next    = ST_ACK;
      end
      ST_DONE: begin
        w_done_now = r_grant ? 2'b10 : 2'b01;
        w_next     = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_idx   <= '0;
      r_done  <= 2'b00;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_now;
      if (w_take) begin
        r_grant <= w_arb_grant;
        r_idx   <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + c_IDX_W'(1);
      end
    end
  end

  assign char_addr = {r_grant, r_idx[c_IDX_W-2:0]};
  assign done      = r_done;
  assign active    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/lcd_line_sched.md
# lcd_line_sched

Line-update scheduler for the 16x2 character LCD on the BER display path. Two requesters (line 0: BER readout, line 1: status text) pulse `start` to request a redraw. The block arbitrates round-robin and sequences one DDRAM set-address command plus `LINE_LEN` character writes into the low-level LCD write driver, pacing every write on `lcd_busy`. Characters are fetched from the shared text RAM, which has 1-cycle read latency.

## Interface
- `LINE_LEN`, 16: characters per line.
- `LINE0_ADDR`, 8'h00: DDRAM base address of line 0.
- `LINE1_ADDR`, 8'h40: DDRAM base address of line 1.
- `CLK`  in  1  system clock; everything is on the rising edge.
- `RST`  in  1  reset, synchronous, active-low.
- `start`  in  2  per-line redraw request; a 1-cycle pulse per bit.
- `done`  out  2  1-cycle pulse when the line's last character write completes.
- `char_addr`  out  1+$clog2(LINE_LEN)  text RAM address, {line, index}.
- `char_data`  in  8  text RAM data, valid the cycle after `char_addr`.
- `lcd_we`  out  1  1-cycle write strobe to the LCD driver.
- `lcd_rs`  out  1  0 = command, 1 = data.
- `lcd_data`  out  8  command or character byte.
- `lcd_busy`  in  1  driver busy; rises the cycle after `lcd_we` and stays high until the write completes.
- `active`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `pending[1:0]`: `start[i]` sets `pending[i]`.
  - A grant clears the granted bit.
  - If set and clear hit the same bit in the same cycle, set wins. A `start` during service of the same line therefore queues exactly one redraw.
- Arbitration in IDLE:
  - Only one line pending: that line is granted.
  - Both pending: the line other than `last_grant` is granted.
  - `last_grant` resets to 1, so line 0 wins the first tie.
- FSM states are IDLE, CMD, ACK, BUSYW, FETCH, DATA, DONE.
  - IDLE: if any bit is pending, latch `grant`, clear `idx`, go to CMD.
  - CMD: when `lcd_busy`=0, issue `lcd_we`=1, `lcd_rs`=0, `lcd_data`=8'h80|base, where base is `LINE0_ADDR` or `LINE1_ADDR`. Go to ACK.
  - ACK: one cycle in which `lcd_busy` is ignored. Go to BUSYW.
  - BUSYW: wait for `lcd_busy`=0. Then go to DONE if `idx`==`LINE_LEN`, otherwise to FETCH.
  - FETCH: drive `char_addr`={grant, idx}. Go to DATA.
  - DATA: issue `lcd_we`=1, `lcd_rs`=1, `lcd_data`=`char_data`. Increment `idx`. Go to ACK.
  - DONE: pulse `done[grant]`, set `last_grant`=grant. Go to IDLE.
- `lcd_we` is combinational: (CMD & !lcd_busy) | DATA. `lcd_rs` and `lcd_data` are valid only while `lcd_we`=1.
- Width rules:
  - `idx` is $clog2(LINE_LEN)+1 bits, so it can reach `LINE_LEN` without wrapping.
  - `char_addr` uses `idx` truncated to its low bits.
- Exactly one command and `LINE_LEN` data writes are issued per grant, regardless of `start` activity during service.

## Timing
- Reset values: `done`=0, `lcd_we`=0, `lcd_rs`=0, `lcd_data`=0, `char_addr`=0, `active`=0, `pending`=0, `last_grant`=1, state=IDLE.
- Reset asserted mid-line: the next edge returns the block to IDLE, drops all pending requests, and issues no further strobes. A partially drawn line is not resumed.
- Start-to-command latency: `start` sampled at edge k, FSM in CMD after edge k+1, `lcd_we` high in that cycle if `lcd_busy`=0.
- Per-character cost is ACK(1) + B busy cycles + BUSYW exit(1) + FETCH(1) + DATA(1), i.e. B+4 cycles.
- Line cost is (LINE_LEN+1)·(B+3)+LINE_LEN+2 cycles from the CMD issue to the `done` pulse inclusive, with constant B.
- Back-to-back lines: after DONE there is one IDLE cycle before the next CMD.

## Configuration
- `LCD_BLANK_PAD_EN` defined: in DATA, a `char_data` of 8'h00 is written as 8'h20 (space), so unwritten RAM shows blanks.
- `LCD_BLANK_PAD_EN` undefined: `char_data` passes through unmodified.

## Structure
- Shared package `lcd_pkg`:
  - FSM state enum.
  - Command constants `LCD_CMD_SET_DDRAM`=8'h80 and `LCD_CHAR_SPACE`=8'h20.
  - Default line base addresses.
- Sub-module `lcd_rr_arb2`: 2-way round-robin arbiter holding `pending` and `last_grant`. Inputs are `start`, `grant_take` and `done`; output is `grant_valid`/`grant`.
- The FSM and `idx` counter stay in the top level.

## Test plan
- Pulse `start`=2'b01 with a driver model where B=5 → command 8'h80, then 16 data writes with RAM[0..15], one `done`=2'b01 pulse, and line cost per the Timing formula.
- `start`=2'b11 in the same cycle after reset → line 0 is serviced completely, then line 1 with command 8'hC0. `done` pulses 01, then 10.
- `start[0]` re-pulsed during the 8th character of line 0 → line 0 is redrawn once more afterwards, and only once.
- Hold `lcd_busy`=1 for 20 cycles before CMD → no `lcd_we` until busy falls, then the command is issued in that cycle.
- Assert `RST`=0 during character 5 → the block is in IDLE with all outputs at reset values on the next edge, and no `done` pulse occurs.
- With `LCD_BLANK_PAD_EN` defined and RAM[3]=8'h00 → the 4th data write carries 8'h20. Without the macro it carries 8'h00.
